// File: rtl/mux_rr_stream.sv
// N-channel registered stream multiplexer: one input channel is granted per cycle (fixed
// select or round-robin) and its word is loaded into a single valid/ready output register.
module mux_rr_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1,
  parameter int CH_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [CH_W-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Handshake: a word moves on any interface at a rising edge where valid and ready are
  // both high; valid never waits on ready, ready may depend on valid of the same channel.

  logic              load;
  logic              grant;
  logic              xfer;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   ptr;
  logic [WIDTH-1:0]  g_data;
  logic              hi_hit;
  logic              lo_hit;
  logic [CH_W-1:0]   hi_g;
  logic [CH_W-1:0]   lo_g;

  assign load = !out_valid || out_ready;
  assign xfer = load && grant && !rst;

  // Round-robin: lowest valid channel at or above ptr, else lowest valid channel overall.
  always_comb begin : grant_logic
    grant  = 1'b0;
    g      = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_g   = '0;
    lo_g   = '0;
    if (MODE == 0) begin
      for (int k = 0; k < N; k++) begin
        if (sel == CH_W'(k) && in_valid[k]) begin
          grant = 1'b1;
          g     = CH_W'(k);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[k] && (k >= int'(ptr))) begin
          hi_hit = 1'b1;
          hi_g   = CH_W'(k);
        end
        if (in_valid[k]) begin
          lo_hit = 1'b1;
          lo_g   = CH_W'(k);
        end
      end
      grant = hi_hit || lo_hit;
      g     = hi_hit ? hi_g : lo_g;
    end
  end

  always_comb begin : data_mux
    g_data = '0;
    for (int k = 0; k < N; k++) begin
      if (g == CH_W'(k)) g_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin : ready_decode
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = xfer && (g == CH_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant) begin
        out_data  <= g_data;
        out_ch    <= g;
        out_valid <= 1'b1;
        if (MODE != 0) ptr <= (int'(g) == N - 1) ? '0 : g + CH_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: a round-robin unit (u0) and a fixed-select unit (u1), checked by
// a cycle model feeding an expected-word queue, a vector table and hand-written sequences.
module tb_mux_rr_stream;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int CH_W  = 2;
  localparam int W     = CH_W + WIDTH;

  logic             clk;
  logic             rst       [2];
  logic [31:0]      in_data   [2];
  logic [3:0]       in_valid  [2];
  logic [3:0]       in_ready  [2];
  logic [1:0]       sel       [2];
  logic [7:0]       out_data  [2];
  logic [1:0]       out_ch    [2];
  logic             out_valid [2];
  logic             out_ready [2];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  bit m_ov     [2];
  int m_ptr    [2];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  localparam logic [31:0] D  = 32'hA3A2A1A0;
  localparam logic [31:0] D5 = 32'hA35CA1A0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic [1:0]  ech;
    logic [7:0]  edat;
  } vec_t;
  vec_t tbl [12];

  mux_rr_stream #(.WIDTH(WIDTH), .N(N), .MODE(1)) u_rr (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sel(sel[0]), .out_data(out_data[0]), .out_ch(out_ch[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  mux_rr_stream #(.WIDTH(WIDTH), .N(N), .MODE(0)) u_fx (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sel(sel[1]), .out_data(out_data[1]), .out_ch(out_ch[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_grant(input bit rr, input logic [3:0] v, input logic [1:0] s,
                                      input int p, output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (!rr) begin
      if (v[s]) begin
        ok = 1'b1;
        g  = int'(s);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (p + i) % N;
        if (!ok && v[k]) begin
          ok = 1'b1;
          g  = k;
        end
      end
    end
  endfunction

  // scoreboard: model predicts grants, pushes expected words, compares on the output side
  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 2; u++) begin
        bit ok;
        bit ld;
        int g;
        logic [3:0]   er;
        logic [W-1:0] front;
        logic [W-1:0] word;
        ld = !m_ov[u] || out_ready[u];
        model_grant(u == 0, in_valid[u], sel[u], m_ptr[u], ok, g);
        er = (ok && ld && !rst[u]) ? 4'(1 << g) : 4'b0000;
        chk(u == 0 ? "sb_in_ready_u0" : "sb_in_ready_u1", 32'(in_ready[u]), 32'(er));
        chk(u == 0 ? "sb_out_valid_u0" : "sb_out_valid_u1", 32'(out_valid[u]), 32'(m_ov[u]));
        if (m_ov[u]) begin
          if (u == 0) front = (exp_q0.size() > 0) ? exp_q0[0] : 'x;
          else        front = (exp_q1.size() > 0) ? exp_q1[0] : 'x;
          chk(u == 0 ? "sb_word_u0" : "sb_word_u1", 32'({out_ch[u], out_data[u]}), 32'(front));
        end
        if (rst[u]) begin
          if (u == 0) exp_q0.delete(); else exp_q1.delete();
          m_ov[u]  = 1'b0;
          m_ptr[u] = 0;
        end else if (ld) begin
          if (m_ov[u] && out_ready[u]) begin
            if (u == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
            if (u == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
          end
          if (ok) begin
            word = {2'(g), in_data[u][g*8 +: 8]};
            if (u == 0) exp_q0.push_back(word); else exp_q1.push_back(word);
            m_ov[u] = 1'b1;
            if (u == 0) m_ptr[u] = (g + 1) % N;
          end else begin
            m_ov[u] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{4'b1111, D,  1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{4'b1111, D,  1'b1, 4'b0010, 1'b1, 2'd0, 8'hA0};
    tbl[2]  = '{4'b1111, D,  1'b1, 4'b0100, 1'b1, 2'd1, 8'hA1};
    tbl[3]  = '{4'b1111, D,  1'b1, 4'b1000, 1'b1, 2'd2, 8'hA2};
    tbl[4]  = '{4'b1111, D,  1'b1, 4'b0001, 1'b1, 2'd3, 8'hA3};
    tbl[5]  = '{4'b0000, D,  1'b1, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[6]  = '{4'b0000, D,  1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[7]  = '{4'b0100, D5, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00};
    tbl[8]  = '{4'b0100, D5, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5C};
    tbl[9]  = '{4'b1100, D5, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h5C};
    tbl[10] = '{4'b0101, D5, 1'b1, 4'b0001, 1'b1, 2'd3, 8'hA3};
    tbl[11] = '{4'b0000, D5, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA0};

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; in_data[u] = D; in_valid[u] = 4'b1111;
      sel[u] = 2'd0; out_ready[u] = 1'b1;
      m_ov[u] = 1'b0; m_ptr[u] = 0;
    end

    // reset held with all channels valid
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #3;
      for (int u = 0; u < 2; u++) begin
        chk("rst_out_valid", 32'(out_valid[u]), 32'd0);
        chk("rst_out_data", 32'(out_data[u]), 32'd0);
        chk("rst_out_ch", 32'(out_ch[u]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[u]), 32'd0);
      end
    end

    // round-robin vector table on u0; u1 idle
    in_valid[1] = 4'b0000;
    rst[1] = 1'b0;
    for (int r = 0; r < 12; r++) begin
      tick();
      rst[0] = 1'b0;
      in_valid[0] = tbl[r].v; in_data[0] = tbl[r].d; out_ready[0] = tbl[r].ordy;
      #3;
      chk("tbl_in_ready", 32'(in_ready[0]), 32'(tbl[r].er));
      chk("tbl_out_valid", 32'(out_valid[0]), 32'(tbl[r].eov));
      if (tbl[r].eov) begin
        chk("tbl_out_ch", 32'(out_ch[0]), 32'(tbl[r].ech));
        chk("tbl_out_data", 32'(out_data[0]), 32'(tbl[r].edat));
      end
    end

    // back-pressure: ch1 waits three stalled cycles, then loads with no bubble
    tick(); in_valid[0] = 4'b0010; in_data[0] = D; out_ready[0] = 1'b1; #3;
    chk("bp_first_ready", 32'(in_ready[0]), 32'b0010);
    for (int c = 0; c < 3; c++) begin
      tick(); out_ready[0] = 1'b0; #3;
      chk("bp_stall_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_stall_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_stall_data", 32'(out_data[0]), 32'hA1);
    end
    tick(); out_ready[0] = 1'b1; in_data[0] = 32'hA3A2B1A0; #3;
    chk("bp_release_ready", 32'(in_ready[0]), 32'b0010);
    chk("bp_release_data", 32'(out_data[0]), 32'hA1);

    // reset during a stalled word, then first grant goes to ch0
    tick(); rst[0] = 1'b1; out_ready[0] = 1'b0; in_valid[0] = 4'b0000; #3;
    chk("nobubble_valid", 32'(out_valid[0]), 32'd1);
    chk("nobubble_data", 32'(out_data[0]), 32'hB1);
    chk("rst_mid_ready", 32'(in_ready[0]), 32'd0);
    tick(); rst[0] = 1'b0; in_valid[0] = 4'b1111; in_data[0] = D; out_ready[0] = 1'b1; #3;
    chk("rst_mid_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_mid_grant", 32'(in_ready[0]), 32'b0001);
    tick(); in_valid[0] = 4'b0000; #3;
    chk("rst_mid_ch", 32'(out_ch[0]), 32'd0);
    chk("rst_mid_data", 32'(out_data[0]), 32'hA0);

    // fixed select on u1
    tick(); sel[1] = 2'd0; in_valid[1] = 4'b0011; in_data[1] = D; out_ready[1] = 1'b1; #3;
    chk("fx_sel0_ready", 32'(in_ready[1]), 32'b0001);
    tick(); sel[1] = 2'd2; #3;
    chk("fx_sel2_ready", 32'(in_ready[1]), 32'd0);
    chk("fx_sel0_ch", 32'(out_ch[1]), 32'd0);
    tick(); sel[1] = 2'd1; #3;
    chk("fx_nogrant_valid", 32'(out_valid[1]), 32'd0);
    chk("fx_sel1_ready", 32'(in_ready[1]), 32'b0010);
    tick(); sel[1] = 2'd3; in_valid[1] = 4'b1000; #3;
    chk("fx_sel1_ch", 32'(out_ch[1]), 32'd1);
    chk("fx_sel1_data", 32'(out_data[1]), 32'hA1);
    chk("fx_sel3_ready", 32'(in_ready[1]), 32'b1000);
    tick(); in_valid[1] = 4'b0000; #3;
    chk("fx_sel3_data", 32'(out_data[1]), 32'hA3);

    // random traffic on both units, checked by the scoreboard
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        rst[u]       = ($urandom_range(0, 59) == 0);
        in_valid[u]  = 4'($urandom_range(0, 15));
        in_data[u]   = $urandom();
        sel[u]       = 2'($urandom_range(0, 3));
        out_ready[u] = ($urandom_range(0, 3) != 0);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        rst[u] = 1'b0; in_valid[u] = 4'b0000; out_ready[u] = 1'b1;
      end
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
